// File: rtl/sample_capture_ctrl.sv
// Capture stage ahead of the file writer: drops pipeline-latency samples, decimates,
// forwards a fixed number of samples, then closes the file with a stop pulse.
module sample_capture_ctrl #(
  parameter int RegisterLength = 16,
  parameter int SkipCount      = 0,
  parameter int DecimFactor    = 1,
  parameter int CaptureCount   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      dataValid,
  input  logic [RegisterLength-1:0] dataIn,
  output logic                      writerRst,
  output logic [RegisterLength-1:0] dataOut,
  output logic                      en,
  output logic                      stop,
  output logic                      done,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SKIP    = 3'd1,
    CAPTURE = 3'd2,
    STOP    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [31:0] SKIP_N     = 32'(SkipCount);
  localparam logic [31:0] CAP_N      = 32'(CaptureCount);
  localparam logic [31:0] DECIM_LAST = 32'(DecimFactor - 1);

  state_t                    state, state_n;
  logic [31:0]               skip_cnt, skip_n;
  logic [31:0]               phase_cnt, phase_n;
  logic [31:0]               cap_cnt, cap_n;
  logic                      wr_rst_n, en_n, stop_n, done_n;
  logic [RegisterLength-1:0] dout_n;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      phase_cnt <= '0;
      cap_cnt   <= '0;
      writerRst <= 1'b1;
      dataOut   <= '0;
      en        <= 1'b0;
      stop      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      skip_cnt  <= skip_n;
      phase_cnt <= phase_n;
      cap_cnt   <= cap_n;
      writerRst <= wr_rst_n;
      dataOut   <= dout_n;
      en        <= en_n;
      stop      <= stop_n;
      done      <= done_n;
    end
  end

  // Outputs are computed here as next values, so every strobe lands one cycle
  // after the input that caused it; stop therefore follows the last en directly.
  always_comb begin
    state_n  = state;
    skip_n   = skip_cnt;
    phase_n  = phase_cnt;
    cap_n    = cap_cnt;
    wr_rst_n = writerRst;
    dout_n   = dataOut;
    en_n     = 1'b0;
    stop_n   = 1'b0;
    done_n   = done;
    case (state)
      IDLE: begin
        wr_rst_n = 1'b1;
        if (arm) begin
          wr_rst_n = 1'b0;
          phase_n  = '0;
          if (SKIP_N != 32'd0)     state_n = SKIP;
          else if (CAP_N != 32'd0) state_n = CAPTURE;
          else                     state_n = STOP;
        end
      end
      SKIP: begin
        if (dataValid) begin
          skip_n = skip_cnt + 32'd1;
          if (skip_cnt + 32'd1 == SKIP_N) begin
            phase_n = '0;
            state_n = (CAP_N != 32'd0) ? CAPTURE : STOP;
          end
        end
      end
      CAPTURE: begin
        if (dataValid) begin
          phase_n = (phase_cnt >= DECIM_LAST) ? 32'd0 : phase_cnt + 32'd1;
          if (phase_cnt == 32'd0) begin
            dout_n = dataIn;
            en_n   = 1'b1;
            cap_n  = cap_cnt + 32'd1;
            if (cap_cnt + 32'd1 == CAP_N) state_n = STOP;
          end
        end
      end
      STOP: begin
        stop_n  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Bench for sample_capture_ctrl: five parameterisations, directed and random streams,
// each checked cycle by cycle against an index-arithmetic reference model.
module tb_sample_capture_ctrl;

  localparam int MAXC = 160;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_w[5];
  logic        arm_w[5];
  logic        val_w[5];
  logic [15:0] dat_w[5];
  logic        wr_w[5];
  logic        en_w[5];
  logic        stop_w[5];
  logic        done_w[5];
  logic [2:0]  st_w[5];
  logic [15:0] dout0, dout1, dout3, dout4;
  logic [7:0]  dout2;

  // instance:   0      1      2      3      4
  int p_s[5] = '{0,     3,     0,     0,     2};
  int p_d[5] = '{1,     2,     1,     1,     3};
  int p_c[5] = '{4,     3,     2,     0,     8};

  sample_capture_ctrl #(.RegisterLength(16), .SkipCount(0), .DecimFactor(1), .CaptureCount(4)) u0 (
    .clk(clk), .rst(rst_w[0]), .arm(arm_w[0]), .dataValid(val_w[0]), .dataIn(dat_w[0]),
    .writerRst(wr_w[0]), .dataOut(dout0), .en(en_w[0]), .stop(stop_w[0]), .done(done_w[0]),
    .state_dbg(st_w[0]));
  sample_capture_ctrl #(.RegisterLength(16), .SkipCount(3), .DecimFactor(2), .CaptureCount(3)) u1 (
    .clk(clk), .rst(rst_w[1]), .arm(arm_w[1]), .dataValid(val_w[1]), .dataIn(dat_w[1]),
    .writerRst(wr_w[1]), .dataOut(dout1), .en(en_w[1]), .stop(stop_w[1]), .done(done_w[1]),
    .state_dbg(st_w[1]));
  sample_capture_ctrl #(.RegisterLength(8), .SkipCount(0), .DecimFactor(1), .CaptureCount(2)) u2 (
    .clk(clk), .rst(rst_w[2]), .arm(arm_w[2]), .dataValid(val_w[2]), .dataIn(dat_w[2][7:0]),
    .writerRst(wr_w[2]), .dataOut(dout2), .en(en_w[2]), .stop(stop_w[2]), .done(done_w[2]),
    .state_dbg(st_w[2]));
  sample_capture_ctrl #(.RegisterLength(16), .SkipCount(0), .DecimFactor(1), .CaptureCount(0)) u3 (
    .clk(clk), .rst(rst_w[3]), .arm(arm_w[3]), .dataValid(val_w[3]), .dataIn(dat_w[3]),
    .writerRst(wr_w[3]), .dataOut(dout3), .en(en_w[3]), .stop(stop_w[3]), .done(done_w[3]),
    .state_dbg(st_w[3]));
  sample_capture_ctrl #(.RegisterLength(16), .SkipCount(2), .DecimFactor(3), .CaptureCount(8)) u4 (
    .clk(clk), .rst(rst_w[4]), .arm(arm_w[4]), .dataValid(val_w[4]), .dataIn(dat_w[4]),
    .writerRst(wr_w[4]), .dataOut(dout4), .en(en_w[4]), .stop(stop_w[4]), .done(done_w[4]),
    .state_dbg(st_w[4]));

  int checks = 0;
  int errors = 0;

  int          n;
  bit          s_rst[MAXC], s_arm[MAXC], s_val[MAXC];
  logic [15:0] s_dat[MAXC];
  logic        o_en[MAXC+1], o_stop[MAXC+1], o_done[MAXC+1], o_wr[MAXC+1];
  logic [2:0]  o_st[MAXC+1];
  logic [15:0] o_dat[MAXC+1];
  bit          e_en[MAXC+1], e_stop[MAXC+1], e_done[MAXC+1], e_wr[MAXC+1], e_rst[MAXC+1];
  logic [15:0] e_dat[MAXC+1];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fresh stream: three reset cycles, then everything quiet.
  task automatic clr(input int len);
    n = len;
    for (int i = 0; i < MAXC; i++) begin
      s_rst[i] = (i >= 3);
      s_arm[i] = 1'b0;
      s_val[i] = 1'b0;
      s_dat[i] = 16'h0;
    end
  endtask

  // Input row i is applied after output row i is sampled, so its effect shows in row i+1.
  task automatic run(input int idx);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      o_en[i]   = en_w[idx];
      o_stop[i] = stop_w[idx];
      o_done[i] = done_w[idx];
      o_wr[i]   = wr_w[idx];
      o_st[i]   = st_w[idx];
      case (idx)
        0:       o_dat[i] = dout0;
        1:       o_dat[i] = dout1;
        2:       o_dat[i] = {8'h00, dout2};
        3:       o_dat[i] = dout3;
        default: o_dat[i] = dout4;
      endcase
      if (i < n) begin
        rst_w[idx] = s_rst[i];
        arm_w[idx] = s_arm[i];
        val_w[idx] = s_val[i];
        dat_w[idx] = s_dat[i];
      end
    end
  endtask

  // Reference: the k-th valid sample after arm is written iff k>=S, (k-S)%D==0 and
  // (k-S)/D<C; en follows it by one cycle, stop follows the final one by two.
  task automatic model(input int idx);
    int S, D, C, k, m, stop_at;
    bit armed;
    logic [15:0] mask, last;
    S = p_s[idx]; D = p_d[idx]; C = p_c[idx];
    mask = (idx == 2) ? 16'h00FF : 16'hFFFF;
    exp_q.delete();
    armed = 1'b0; stop_at = -1; last = 16'h0; k = 0;
    for (int j = 0; j <= n; j++) begin
      e_en[j] = 0; e_stop[j] = 0; e_done[j] = 0; e_wr[j] = 1; e_rst[j] = 0; e_dat[j] = 16'h0;
    end
    for (int i = 0; i < n; i++) begin
      int j;
      j = i + 1;
      if (!s_rst[i]) begin
        armed = 1'b0; stop_at = -1; last = 16'h0; e_rst[j] = 1;
      end else begin
        if (!armed) begin
          if (s_arm[i]) begin
            armed = 1'b1; k = 0;
            if (S == 0 && C == 0) stop_at = j + 1;
          end
        end else if (stop_at < 0 && s_val[i]) begin
          if (k < S) begin
            if (k == S - 1 && C == 0) stop_at = j + 1;
          end else begin
            m = k - S;
            if (m % D == 0 && m / D < C) begin
              e_en[j] = 1;
              last = s_dat[i] & mask;
              exp_q.push_back(last);
              if (m / D == C - 1) stop_at = j + 1;
            end
          end
          k++;
        end
        e_wr[j]   = !armed;
        e_dat[j]  = last;
        e_stop[j] = (stop_at == j);
        e_done[j] = (stop_at >= 0 && j > stop_at);
      end
    end
  endtask

  task automatic compare(input string name);
    for (int j = 1; j <= n; j++) begin
      check($sformatf("%s en c%0d", name, j), o_en[j], e_en[j]);
      check($sformatf("%s stop c%0d", name, j), o_stop[j], e_stop[j]);
      check($sformatf("%s done c%0d", name, j), o_done[j], e_done[j]);
      check($sformatf("%s writerRst c%0d", name, j), o_wr[j], e_wr[j]);
      check($sformatf("%s dataOut c%0d", name, j), o_dat[j], e_dat[j]);
      if (e_rst[j]) check($sformatf("%s idle_after_rst c%0d", name, j), o_st[j], 32'd0);
      if (o_en[j] === 1'b1) begin
        if (exp_q.size() > 0) check($sformatf("%s write_data c%0d", name, j), o_dat[j], exp_q.pop_front());
        else check($sformatf("%s unexpected_write c%0d", name, j), o_en[j], 32'd0);
      end
    end
    check($sformatf("%s pending_writes", name), exp_q.size(), 32'd0);
  endtask

  task automatic do_test(input string name, input int idx);
    run(idx);
    model(idx);
    compare(name);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      rst_w[i] = 1'b0; arm_w[i] = 1'b0; val_w[i] = 1'b0; dat_w[i] = 16'h0;
    end

    clr(20); s_arm[4] = 1;
    for (int q = 0; q < 6; q++) begin s_val[5+q] = 1; s_dat[5+q] = 16'(10 + q); end
    do_test("basic", 0);

    clr(50); s_arm[4] = 1;
    for (int q = 0; q <= 20; q++) begin s_val[5+2*q] = 1; s_dat[5+2*q] = 16'(q); end
    do_test("skip_decim", 1);

    clr(14); s_arm[4] = 1;
    s_val[5] = 1; s_dat[5] = 16'h0080;
    s_val[6] = 1; s_dat[6] = 16'h00FF;
    do_test("signed8", 2);

    clr(16); s_arm[4] = 1;
    for (int q = 5; q < 10; q++) begin s_val[q] = 1; s_dat[q] = 16'($urandom); end
    do_test("count0", 3);

    clr(20); s_arm[4] = 1; s_val[4] = 1; s_dat[4] = 16'd99;
    for (int q = 0; q < 6; q++) begin s_val[5+q] = 1; s_dat[5+q] = 16'(200 + q); end
    do_test("arm_with_valid", 0);

    clr(140); s_arm[4] = 1;
    for (int q = 5; q < 17; q++) begin s_val[q] = 1; s_dat[q] = 16'($urandom); end
    s_rst[17] = 0; s_arm[20] = 1;
    for (int q = 21; q < 140; q++) begin
      s_val[q] = ($urandom_range(0, 3) != 0); s_dat[q] = 16'($urandom);
    end
    do_test("midrun_reset", 4);

    for (int r = 0; r < 10; r++) begin
      clr(120);
      for (int q = 3; q < 120; q++) begin
        s_arm[q] = ($urandom_range(0, 7) == 0);
        s_val[q] = ($urandom_range(0, 2) != 0);
        s_dat[q] = 16'($urandom);
        if (q > 30) s_rst[q] = ($urandom_range(0, 59) != 0);
      end
      do_test($sformatf("random%0d", r), r % 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
